// File: rtl/booth_pkg.sv
// Shared types and Booth recoding helpers for the radix-4 sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_ZERO = 3'd0;
    localparam sel_t SEL_P1   = 3'd1;
    localparam sel_t SEL_P2   = 3'd2;
    localparam sel_t SEL_M1   = 3'd3;
    localparam sel_t SEL_M2   = 3'd4;

    // Radix-4 Booth recoding of one overlapping 3-bit window of the multiplier.
    function automatic sel_t booth_sel(input logic [2:0] win);
        sel_t sel;
        case (win)
            3'b001, 3'b010: sel = SEL_P1;
            3'b011:         sel = SEL_P2;
            3'b100:         sel = SEL_M2;
            3'b101, 3'b110: sel = SEL_M1;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: picks 0, +-md or +-2md for one Booth window.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] md_i,
    input  logic [2:0]   win_i,
    output logic [N+1:0] pp_o
);

    logic [N+1:0] md_ext;
    logic [N+1:0] md_x2;
    sel_t         sel;

    // Work at N+2 bits so negating or doubling the most negative md cannot overflow.
    always_comb begin
        md_ext = {{2{md_i[N-1]}}, md_i};
        md_x2  = {md_ext[N:0], 1'b0};
        sel    = booth_sel(win_i);
        case (sel)
            SEL_P1:  pp_o = md_ext;
            SEL_P2:  pp_o = md_x2;
            SEL_M1:  pp_o = -md_ext;
            SEL_M2:  pp_o = -md_x2;
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller and accumulator for a radix-4 Booth multiplier:
// one Booth digit per clock, valid/ready handshakes on operands and product.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  md,
    input  logic [N-1:0]                  mr,
    input  logic                          abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*N-1:0]                out,
    output logic                          busy,
    output logic [$clog2(N/2)-1:0]        digit_idx
);

    localparam int unsigned DIGITS = N / 2;
    localparam int unsigned CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LastDigit = CW'(DIGITS - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    md_q, md_d;
    logic [N:0]      win_q, win_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   digit_q, digit_d;

    logic [N+1:0]    pp;
    logic [2*N-1:0]  pp_ext;
    logic [2*N-1:0]  pp_sh;
    logic [2*N-1:0]  sum;

    booth_pp_gen #(
        .N (N)
    ) u_pp_gen (
        .md_i  (md_q),
        .win_i (win_q[2:0]),
        .pp_o  (pp)
    );

    // Align the current partial product to its digit weight and add it in.
    always_comb begin
        pp_ext = {{(N - 2){pp[N+1]}}, pp};
        pp_sh  = pp_ext << {digit_q, 1'b0};
        sum    = acc_q + pp_sh;
    end

    // Next-state logic for FSM, operand window, digit counter and accumulator.
    always_comb begin
        state_d     = state_q;
        md_d        = md_q;
        win_d       = win_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        digit_d     = digit_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    md_d    = md;
                    win_d   = {mr, 1'b0};
                    acc_d   = '0;
                    digit_d = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                // Abort beats the final digit, so a cancelled job never emits a product.
                if (abort) begin
                    acc_d   = '0;
                    digit_d = '0;
                    state_d = StIdle;
                end else begin
                    acc_d = sum;
                    win_d = {{2{win_q[N]}}, win_q[N:2]};
                    if (digit_q == LastDigit) begin
                        out_d       = sum;
                        out_valid_d = 1'b1;
                        digit_d     = '0;
                        state_d     = StDone;
                    end else begin
                        digit_d = digit_q + CW'(1);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            md_q        <= '0;
            win_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            digit_q     <= '0;
        end else begin
            state_q     <= state_d;
            md_q        <= md_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            digit_q     <= digit_d;
        end
    end

    // Control outputs come only from registers, never from the handshake inputs.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out       = out_q;
        out_valid = out_valid_q;
        digit_idx = digit_q;
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: a driver pushes expected products into a
// scoreboard queue and a monitor pops and compares whenever a product is handed off.
module tb_booth_seq_ctrl;

    localparam int N = 16;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    md;
    logic [N-1:0]    mr;
    logic            abort;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out;
    logic            busy;
    logic [2:0]      digit_idx;

    int n_vec = 0;
    int n_err = 0;
    logic [2*N-1:0] exp_q[$];

    booth_seq_ctrl #(
        .N (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .md        (md),
        .mr        (mr),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy),
        .digit_idx (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: plain signed arithmetic, truncated to 2N bits.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        logic [63:0] pv;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        return pv[2*N-1:0];
    endfunction

    // Monitor: a product is consumed at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_product", {32'd0, out}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                chk("product", {32'd0, out}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    endtask

    // Present one operand pair; returns just after the accepting edge.
    task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
        wait_ready();
        in_valid = 1'b1;
        md       = a;
        mr       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        md       = N'($urandom);
        mr       = N'($urandom);
    endtask

    // Full transaction: latency check, optional backpressure, output handshake.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input int bp);
        int k;
        logic [2*N-1:0] held;
        out_ready = (bp == 0);
        accept(a, b);
        exp_q.push_back(exp);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (!out_valid && k < 8) chk("digit_idx", {61'd0, digit_idx}, 64'(k));
        end while (!out_valid && k < 20);
        chk("latency", 64'(k), 64'd8);
        chk("digit_idx_done", {61'd0, digit_idx}, 64'd0);
        chk("busy_done", {63'd0, busy}, 64'd1);
        held = out;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            md       = N'($urandom);
            mr       = N'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_out", {32'd0, out}, {32'd0, held});
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_after_hs", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_hs", {63'd0, in_ready}, 64'd1);
        chk("out_kept", {32'd0, out}, {32'd0, exp});
    endtask

    initial begin
        in_valid  = 1'b0;
        md        = '0;
        mr        = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #23;
        chk("rst_out", {32'd0, out}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_digit", {61'd0, digit_idx}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed products with hand-computed results.
        do_op(16'd3, 16'd5, 32'h0000_000F, 0);
        do_op(16'hFFF9, 16'd6, 32'hFFFF_FFD6, 0);
        do_op(16'h7FFF, 16'h8000, 32'hC000_8000, 0);
        do_op(16'h8000, 16'h8000, 32'h4000_0000, 0);
        do_op(16'h0000, 16'hFFFF, 32'h0000_0000, 0);

        // Backpressure in DONE with ignored operand pulses.
        do_op(16'h1234, 16'hFEDC, ref_mul(16'h1234, 16'hFEDC), 5);

        // Abort during the 4th iteration cycle.
        out_ready = 1'b1;
        accept(16'h7FFF, 16'h7FFF);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_digit", {61'd0, digit_idx}, 64'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        do_op(16'd9, 16'd2, 32'd18, 0);

        // Asynchronous reset between edges while iterating.
        accept(16'h4321, 16'h1357);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_out", {32'd0, out}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_digit", {61'd0, digit_idx}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized products against the arithmetic model.
        for (int i = 0; i < 100; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom);
            b = N'($urandom);
            if (i % 10 == 0) a = 16'h8000;
            do_op(a, b, ref_mul(a, b), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Sequencing controller plus accumulator for the radix-4 Booth multiply datapath.
- Accepts one signed md × mr operand pair over a valid/ready handshake and walks the N/2 Booth windows of mr, one per clock.
- Each cycle it selects 0, ±md or ±2md, aligns that partial product and accumulates it into a 2N-bit result.
- Presents the product over a valid/ready output handshake; sits between the operand source and the result consumer, replacing the free-running count-based capture.

Parameters:
- N, 16, operand width in bits. Must be even and ≥4.
- DIGITS, N/2, number of Booth digits. Derived; do not override.
- CW, $clog2(N/2), width of the digit counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets all state immediately).
- in_valid  in  1  operand pair present.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- md  in  N  multiplicand, signed two's complement.
- mr  in  N  multiplier, signed two's complement.
- abort  in  1  synchronous cancel of the operation in progress.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out  out  2N  signed product md*mr.
- busy  out  1  high in ITER or DONE.
- digit_idx  out  CW  index of the Booth digit processed at the next edge; 0 outside ITER.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, acc=0, out=0, out_valid=0, digit_idx=0, busy=0, in_ready=1.
  - Internal md/window registers are cleared.
  - Any operation in flight is discarded.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch md_r=md, win_r={mr,1'b0} (N+1 bits), acc=0, digit_idx=0, go to ITER.
  - out_valid=0 throughout.
- ITER: every edge, decode window w=win_r[2:0]:
  - 000 or 111 -> 0
  - 001 or 010 -> +md
  - 011 -> +2md
  - 100 -> -2md
  - 101 or 110 -> -md
- Partial product handling:
  - Sign-extend the selected partial product to 2N bits and shift it left by 2*digit_idx.
  - acc += pp, modulo 2^(2N).
  - win_r is shifted right arithmetically by 2; digit_idx increments.
- ITER exit:
  - After the edge processing digit DIGITS-1: out=acc+pp_last, out_valid=1, go to DONE.
  - digit_idx returns to 0.
- Latency:
  - Accept at edge T; out_valid is high from edge T+DIGITS (8 cycles for N=16).
  - Fixed latency; no zero-digit skipping.
- DONE:
  - out and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE. in_ready becomes 1 the following cycle; operands cannot be accepted in the same cycle.
  - out keeps its last value after the handshake until the next product.
- abort:
  - In ITER: go to IDLE next edge, acc=0, no out_valid pulse.
  - Ignored in IDLE and DONE; a finished product is never dropped.
- Simultaneous events:
  - abort and the last-digit edge together: abort wins.
  - in_valid while busy is ignored, since in_ready=0.
- Extreme operands: md=-2^(N-1) is legal.
  - -md and ±2md are computed at N+2 bits before sign-extension, so no overflow is possible.
  - The full product range, including (-2^(N-1))², fits in 2N bits.
- Control outputs: all are registered or decoded directly from the state register; no combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package booth_pkg:
  - state enum (IDLE, ITER, DONE)
  - Booth select encoding constants SEL_ZERO, SEL_P1, SEL_P2, SEL_M1, SEL_M2
  - window-to-select function
- Sub-module booth_pp_gen (combinational): inputs md_r and the 3-bit window; output is the sign-extended N+2-bit partial product.
- FSM, counter, shifting and accumulation stay in booth_seq_ctrl.

Test Plan:
- md=3, mr=5, out_ready=1 -> out_valid rises exactly 8 cycles after accept; out=0x0000000F; in_ready=1 one cycle after the output handshake.
- md=-7 (0xFFF9), mr=6 -> out=0xFFFFFFD6. Also md=0x7FFF, mr=0x8000 -> out=0xC0008000.
- md=0x8000, mr=0x8000 -> out=0x40000000. Also md=0, mr=0xFFFF -> out=0.
- Output backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out stable, in_valid pulses ignored (in_ready=0); out_ready=1 -> IDLE.
- abort in the 4th ITER cycle -> IDLE next edge, no out_valid. Then mr=2, md=9 -> out=18, unaffected by the aborted job.
- reset=0 asynchronously mid-ITER (between edges) -> outputs at reset values immediately. After release, 100 random back-to-back pairs match the signed md*mr reference model.
